// File: rtl/tx_phy_scheduler_pkg.sv
// Shared types and SOP helpers for the PD PHY transmit scheduler.
package tx_phy_scheduler_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSendGcrc,
      StSendMsg,
      StWaitCrc,
      StChkRetry,
      StSendOrd,
      StReportOk,
      StReportFail
   } state_e;

   localparam logic [2:0] SopHardReset  = 3'd5;
   localparam logic [2:0] SopCableReset = 3'd6;

   // Hard Reset, Cable Reset and BIST are ordered sets: no GoodCRC, no MessageID.
   function automatic logic is_ordset(logic [2:0] sop);
      return sop >= SopHardReset;
   endfunction

   // Reset ordered sets pre-empt any message transfer.
   function automatic logic is_reset_req(logic [2:0] sop);
      return (sop == SopHardReset) || (sop == SopCableReset);
   endfunction

endpackage

// File: rtl/tx_phy_scheduler_if.sv
// Start/done handshake between the transmit scheduler and the PHY framer.
interface tx_phy_scheduler_if;

   logic       phy_ready;
   logic       phy_done;
   logic       phy_discard;
   logic       phy_start;
   logic [2:0] phy_sop;
   logic       phy_is_gcrc;

   modport master (
      input  phy_ready,
      input  phy_done,
      input  phy_discard,
      output phy_start,
      output phy_sop,
      output phy_is_gcrc
   );

   modport slave (
      output phy_ready,
      output phy_done,
      output phy_discard,
      input  phy_start,
      input  phy_sop,
      input  phy_is_gcrc
   );

endinterface

// File: rtl/tx_phy_scheduler_crc_rx_timer.sv
// CRCReceiveTimer: counts cycles while enabled, flags the last cycle of tReceive.
module crc_rx_timer #(
   parameter int unsigned          TIMER_W         = 16,
   parameter logic [TIMER_W-1:0]   CRC_TIMEOUT_CYC = TIMER_W'(900)
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam logic [TIMER_W-1:0] TermCnt = CRC_TIMEOUT_CYC - 1'b1;

   logic [TIMER_W-1:0] count_q, count_d;

   // Count register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Next count: clear wins, saturate at the terminal count.
   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && (count_q != TermCnt)) begin
         count_d = count_q + 1'b1;
      end
   end

   // Terminal-count flag during the last enabled cycle.
   always_comb begin
      expired = enable && (count_q == TermCnt);
   end

endmodule

// File: rtl/tx_phy_scheduler.sv
// Arbitrates GoodCRC replies, TRANSMIT requests and retries onto the PD PHY,
// runs the retry/CRC-receive bookkeeping and raises the transmit alerts.
module tx_phy_scheduler
   import tx_phy_scheduler_pkg::*;
#(
   parameter int unsigned          TIMER_W         = 16,
   parameter logic [TIMER_W-1:0]   CRC_TIMEOUT_CYC = TIMER_W'(900)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       tx_req,
   input  logic [2:0]                 tx_sop,
   input  logic [1:0]                 tx_retry_max,
   input  logic                       gcrc_req,
   input  logic [2:0]                 gcrc_sop,
   input  logic                       gcrc_rx,
   tx_phy_scheduler_if.master         phy,
   output logic                       alert_success,
   output logic                       alert_failed,
   output logic                       alert_discarded,
   output logic                       msg_id_inc,
   output logic                       busy
);

   state_e     state_q, state_d;
   logic       gcrc_pend_q, gcrc_pend_d;
   logic [2:0] gcrc_sop_q, gcrc_sop_d;
   logic       tx_pend_q, tx_pend_d;
   logic [2:0] tx_sop_q, tx_sop_d;
   logic [1:0] retry_max_q, retry_max_d;
   logic [1:0] retry_cnt_q, retry_cnt_d;
   logic       start_q, start_d;
   logic [2:0] frame_sop_q, frame_sop_d;
   logic       is_gcrc_q, is_gcrc_d;
   logic       is_ord_q, is_ord_d;
   logic       disc_q, disc_d;
   logic       preempt_q, preempt_d;

   logic       grant_gcrc, grant_tx;
   logic       msg_active, tx_busy, tx_accept, tx_drop, tx_abort;
   logic       crc_expired;

   // A message owns the transmitter from its first start until it reports.
   assign msg_active = (state_q inside {StSendMsg, StWaitCrc, StChkRetry, StSendOrd});
   assign tx_busy    = tx_pend_q || msg_active;
   assign tx_accept  = tx_req && !tx_busy;
   assign tx_drop    = tx_req && tx_busy;
   assign tx_abort   = tx_drop && is_reset_req(tx_sop);

   crc_rx_timer #(
      .TIMER_W         (TIMER_W),
      .CRC_TIMEOUT_CYC (CRC_TIMEOUT_CYC)
   ) u_crc_rx_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_q != StWaitCrc),
      .enable  (state_q == StWaitCrc),
      .expired (crc_expired)
   );

   // State, request latches and registered PHY/alert strobes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= StIdle;
         gcrc_pend_q <= 1'b0;
         gcrc_sop_q  <= '0;
         tx_pend_q   <= 1'b0;
         tx_sop_q    <= '0;
         retry_max_q <= '0;
         retry_cnt_q <= '0;
         start_q     <= 1'b0;
         frame_sop_q <= '0;
         is_gcrc_q   <= 1'b0;
         is_ord_q    <= 1'b0;
         disc_q      <= 1'b0;
         preempt_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         gcrc_pend_q <= gcrc_pend_d;
         gcrc_sop_q  <= gcrc_sop_d;
         tx_pend_q   <= tx_pend_d;
         tx_sop_q    <= tx_sop_d;
         retry_max_q <= retry_max_d;
         retry_cnt_q <= retry_cnt_d;
         start_q     <= start_d;
         frame_sop_q <= frame_sop_d;
         is_gcrc_q   <= is_gcrc_d;
         is_ord_q    <= is_ord_d;
         disc_q      <= disc_d;
         preempt_q   <= preempt_d;
      end
   end

   // Next state, grants, retry count and the strobes that go with transitions.
   always_comb begin
      state_d     = state_q;
      start_d     = 1'b0;
      frame_sop_d = frame_sop_q;
      is_gcrc_d   = is_gcrc_q;
      is_ord_d    = is_ord_q;
      retry_cnt_d = retry_cnt_q;
      disc_d      = 1'b0;
      preempt_d   = 1'b0;
      grant_gcrc  = 1'b0;
      grant_tx    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (phy.phy_ready) begin
               if (gcrc_pend_q) begin
                  grant_gcrc  = 1'b1;
                  state_d     = StSendGcrc;
                  start_d     = 1'b1;
                  frame_sop_d = gcrc_sop_q;
                  is_gcrc_d   = 1'b1;
                  is_ord_d    = 1'b0;
               end else if (tx_pend_q && !tx_abort) begin
                  // A reset arriving this cycle replaces the pending request instead.
                  grant_tx    = 1'b1;
                  start_d     = 1'b1;
                  frame_sop_d = tx_sop_q;
                  is_gcrc_d   = 1'b0;
                  if (is_ordset(tx_sop_q)) begin
                     state_d  = StSendOrd;
                     is_ord_d = 1'b1;
                  end else begin
                     state_d     = StSendMsg;
                     is_ord_d    = 1'b0;
                     retry_cnt_d = '0;
                  end
               end
            end
         end
         StSendGcrc: begin
            if (phy.phy_done || phy.phy_discard) begin
               state_d = StIdle;
            end
         end
         StSendOrd: begin
            if (phy.phy_done) begin
               state_d = StReportOk;
            end else if (phy.phy_discard) begin
               state_d = StIdle;
               disc_d  = 1'b1;
            end
         end
         StSendMsg: begin
            if (phy.phy_done) begin
               state_d = StWaitCrc;
            end else if (phy.phy_discard) begin
               state_d = StChkRetry;
            end
         end
         StWaitCrc: begin
            // GoodCRC acceptance beats both a GoodCRC to send and the timeout.
            if (gcrc_rx) begin
               state_d = StReportOk;
            end else if (gcrc_pend_q) begin
               state_d   = StIdle;
               disc_d    = 1'b1;
               preempt_d = 1'b1;
            end else if (crc_expired) begin
               state_d = StChkRetry;
            end
         end
         StChkRetry: begin
            if (retry_cnt_q == retry_max_q) begin
               state_d = StReportFail;
            end else if (gcrc_pend_q) begin
               state_d   = StIdle;
               disc_d    = 1'b1;
               preempt_d = 1'b1;
            end else if (phy.phy_ready) begin
               state_d     = StSendMsg;
               start_d     = 1'b1;
               retry_cnt_d = retry_cnt_q + 2'd1;
            end
         end
         StReportOk, StReportFail: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // A TRANSMIT write while busy is always rejected; a reset also kills the transfer.
      if (tx_drop) begin
         disc_d = 1'b1;
         if (tx_abort && msg_active) begin
            state_d   = StIdle;
            start_d   = 1'b0;
            preempt_d = 1'b0;
         end
      end
   end

   // Request latches: new strobes set, grants clear.
   always_comb begin
      gcrc_pend_d = gcrc_req || (gcrc_pend_q && !grant_gcrc);
      gcrc_sop_d  = gcrc_req ? gcrc_sop : gcrc_sop_q;
      tx_pend_d   = tx_pend_q;
      tx_sop_d    = tx_sop_q;
      retry_max_d = retry_max_q;
      if (tx_accept || tx_abort) begin
         tx_pend_d   = 1'b1;
         tx_sop_d    = tx_sop;
         retry_max_d = tx_retry_max;
      end else if (grant_tx) begin
         tx_pend_d = 1'b0;
      end
   end

   // Outputs decoded from registered state only.
   always_comb begin
      phy.phy_start   = start_q;
      phy.phy_sop     = frame_sop_q;
      phy.phy_is_gcrc = is_gcrc_q;
      alert_success   = (state_q == StReportOk);
      alert_failed    = (state_q == StReportFail);
      alert_discarded = disc_q;
      msg_id_inc      = ((state_q == StReportOk) && !is_ord_q) ||
                        (state_q == StReportFail) || preempt_q;
      busy            = (state_q != StIdle) || gcrc_pend_q || tx_pend_q;
   end

endmodule
